// File: rtl/hit_map_decoder_if.sv
// Hit coordinate handshake between the map decoder and its consumer.
interface hit_map_decoder_if #(
  parameter int XW = 6,
  parameter int YW = 6
);
  logic          hit_valid;
  logic          hit_ready;
  logic [XW-1:0] hit_x;
  logic [YW-1:0] hit_y;

  modport master (
    output hit_valid, hit_x, hit_y,
    input  hit_ready
  );

  modport slave (
    input  hit_valid, hit_x, hit_y,
    output hit_ready
  );
endinterface

// File: rtl/hit_map_decoder.sv
// Hit-map frame receiver: header hunt, row capture, trailer check, hit scan.
// MAP_ROW_SKIP_EN: skip all-zero rows in one clk during the scan.
module hit_map_decoder #(
  parameter int NROW = 39,
  parameter int NCOL = 39,
  parameter int XW   = 6,
  parameter int YW   = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCOL-1:0]  data_in,
  hit_map_decoder_if.master hit,
  output logic [10:0]      hit_count,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic             frame_drop
);

  function automatic logic [NCOL-1:0] alt_word(input logic msb);
    logic [NCOL-1:0] w;
    for (int i = 0; i < NCOL; i++)
      w[i] = ((NCOL - 1 - i) % 2 == 0) ? msb : ~msb;
    return w;
  endfunction

  localparam logic [NCOL-1:0] HDR_WORD = alt_word(1'b1);
  localparam logic [NCOL-1:0] TRL_WORD = alt_word(1'b0);
  localparam logic [XW-1:0]   X_LAST   = XW'(NROW - 1);
  localparam logic [YW-1:0]   Y_LAST   = YW'(NCOL - 1);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, CHECK, SCAN, DONE
  } state_t;

  state_t          state;
  logic [NCOL-1:0] map [NROW];
  logic [XW-1:0]   row_cnt;
  logic [XW-1:0]   sx;
  logic [YW-1:0]   sy;
  logic            scan_end;
  logic            is_hdr;
  logic            is_trl;
  logic            stall;
  logic            cur_bit;
  logic            skip;

  assign is_hdr  = (data_in == HDR_WORD);
  assign is_trl  = (data_in == TRL_WORD);
  assign stall   = hit.hit_valid && !hit.hit_ready;
  assign cur_bit = map[sx][sy];

`ifdef MAP_ROW_SKIP_EN
  assign skip = (sy == '0) && (map[sx] == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk)
    if (state == CAPTURE)
      map[row_cnt] <= data_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      row_cnt       <= '0;
      sx            <= '0;
      sy            <= '0;
      scan_end      <= 1'b0;
      hit.hit_valid <= 1'b0;
      hit.hit_x     <= '0;
      hit.hit_y     <= '0;
      hit_count     <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      frame_drop    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (is_hdr) begin
            state     <= CAPTURE;
            busy      <= 1'b1;
            row_cnt   <= '0;
            hit_count <= '0;
          end
        end
        CAPTURE: begin
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == X_LAST)
            state <= CHECK;
        end
        CHECK: begin
          if (is_trl) begin
            state    <= SCAN;
            sx       <= '0;
            sy       <= '0;
            scan_end <= 1'b0;
          end else begin
            // the rejected word is consumed here, never re-tried as a header
            frame_err  <= 1'b1;
            frame_drop <= is_hdr;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        SCAN: begin
          frame_drop <= is_hdr;
          if (!stall) begin
            if (hit.hit_valid)
              hit_count <= hit_count + 1'b1;
            if (scan_end) begin
              hit.hit_valid <= 1'b0;
              frame_done    <= 1'b1;
              state         <= DONE;
            end else if (skip) begin
              hit.hit_valid <= 1'b0;
              sy            <= '0;
              sx            <= sx + 1'b1;
              scan_end      <= (sx == X_LAST);
            end else begin
              // an accept and the next hit can land in the same clk
              hit.hit_valid <= cur_bit;
              if (cur_bit) begin
                hit.hit_x <= sx;
                hit.hit_y <= sy;
              end
              if (sy == Y_LAST) begin
                sy       <= '0;
                sx       <= sx + 1'b1;
                scan_end <= (sx == X_LAST);
              end else begin
                sy <= sy + 1'b1;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_map_decoder.sv
// Directed bench for hit_map_decoder: vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_hit_map_decoder;
  localparam int NROW = 39;
  localparam int NCOL = 39;
  localparam logic [NCOL-1:0] HDR  = 39'h55_5555_5555;
  localparam logic [NCOL-1:0] TRL  = 39'h2A_AAAA_AAAA;
  localparam logic [NCOL-1:0] FILL = 39'd999;
`ifdef MAP_ROW_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NCOL-1:0] data_in;
  logic [10:0]     hit_count;
  logic            busy, frame_done, frame_err, frame_drop;

  hit_map_decoder_if hif ();

  hit_map_decoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .hit        (hif),
    .hit_count  (hit_count),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [NCOL-1:0] fmap [NROW];
  int qx[$];
  int qy[$];
  int n_done, n_err, n_drop, done_cyc, unstable;

  typedef struct {
    int x; int y; int stall;
    int exp_x; int exp_y; int exp_cnt;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_map();
    for (int r = 0; r < NROW; r++) fmap[r] = '0;
  endtask

  task automatic send_frame(input logic [NCOL-1:0] trl);
    data_in = HDR;
    tick();
    for (int r = 0; r < NROW; r++) begin
      data_in = fmap[r];
      tick();
    end
    data_in = trl;
    tick();
    data_in = FILL;
  endtask

  task automatic collect(input int stall, input int budget, input int hdr_at);
    int st;
    int hx, hy;
    qx.delete(); qy.delete();
    n_done = 0; n_err = 0; n_drop = 0; done_cyc = -1; unstable = 0;
    st = 0; hx = 0; hy = 0;
    for (int c = 0; c < budget; c++) begin
      if (frame_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (frame_err) n_err++;
      if (frame_drop) n_drop++;
      if (done_cyc >= 0 && c > done_cyc + 2) break;
      if (hif.hit_valid) begin
        if (st == 0) begin
          hx = int'(hif.hit_x);
          hy = int'(hif.hit_y);
        end else if (int'(hif.hit_x) != hx || int'(hif.hit_y) != hy) begin
          unstable++;
        end
        if (st < stall) begin
          hif.hit_ready = 1'b0;
          st++;
        end else begin
          hif.hit_ready = 1'b1;
          qx.push_back(int'(hif.hit_x));
          qy.push_back(int'(hif.hit_y));
          st = 0;
        end
      end else begin
        hif.hit_ready = 1'b1;
      end
      data_in = (c == hdr_at) ? HDR : FILL;
      tick();
    end
    data_in = FILL;
    hif.hit_ready = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int stall);
    int ex[$];
    int ey[$];
    int lat;
    int bad;
    lat = 1;
    bad = -1;
    for (int x = 0; x < NROW; x++) begin
      for (int y = 0; y < NCOL; y++)
        if (fmap[x][y]) begin
          ex.push_back(x);
          ey.push_back(y);
        end
      lat += (SKIP && fmap[x] == '0) ? 1 : NCOL;
    end
    lat += ex.size() * stall;
    chk({tag, " nhits"}, qx.size(), ex.size());
    for (int i = 0; i < ex.size() && i < qx.size(); i++)
      if (bad < 0 && (qx[i] != ex[i] || qy[i] != ey[i])) bad = i;
    chk({tag, " order"}, bad, -1);
    chk({tag, " hit_count"}, hit_count, ex.size());
    chk({tag, " done pulses"}, n_done, 1);
    chk({tag, " done latency"}, done_cyc, lat);
    chk({tag, " stable"}, unstable, 0);
    chk({tag, " err pulses"}, n_err, 0);
  endtask

  initial begin
    int busy_hi;
    int w;
    reset_n = 1'b1;
    data_in = FILL;
    hif.hit_ready = 1'b0;
    #2 reset_n = 1'b0;
    tick(); tick();
    chk("reset outputs",
        {hif.hit_valid, hif.hit_x, hif.hit_y, hit_count,
         busy, frame_done, frame_err, frame_drop}, 0);
    reset_n = 1'b1;
    tick();

    vt[0] = '{3, 5, 0, 3, 5, 1};
    vt[1] = '{0, 0, 0, 0, 0, 1};
    vt[2] = '{38, 38, 0, 38, 38, 1};
    vt[3] = '{0, 38, 2, 0, 38, 1};
    vt[4] = '{20, 0, 1, 20, 0, 1};
    for (int i = 0; i < 5; i++) begin
      clear_map();
      fmap[vt[i].x][vt[i].y] = 1'b1;
      send_frame(TRL);
      collect(vt[i].stall, 2000, -1);
      chk($sformatf("v%0d x", i), qx.size() > 0 ? qx[0] : -1, vt[i].exp_x);
      chk($sformatf("v%0d y", i), qy.size() > 0 ? qy[0] : -1, vt[i].exp_y);
      chk($sformatf("v%0d cnt", i), hit_count, vt[i].exp_cnt);
      check_frame($sformatf("v%0d", i), vt[i].stall);
    end

    clear_map();
    fmap[0][0] = 1'b1; fmap[0][38] = 1'b1; fmap[38][38] = 1'b1;
    send_frame(TRL);
    collect(10, 2000, -1);
    chk("stall cnt", hit_count, 3);
    check_frame("stall", 10);

    clear_map();
    fmap[4][4] = 1'b1;
    send_frame(39'd0);
    collect(0, 60, -1);
    chk("badtrl err", n_err, 1);
    chk("badtrl hits", qx.size(), 0);
    chk("badtrl done", n_done, 0);
    chk("badtrl busy", busy, 0);

    send_frame(HDR);
    collect(0, 60, -1);
    chk("hdrtrl err", n_err, 1);
    chk("hdrtrl drop", n_drop, 1);
    chk("hdrtrl busy", busy, 0);

    clear_map();
    fmap[7][9] = 1'b1;
    send_frame(TRL);
    collect(0, 2000, -1);
    check_frame("after err", 0);

    clear_map();
    fmap[0] = HDR;
    send_frame(TRL);
    collect(0, 2000, -1);
    chk("hdrrow n", qx.size(), 20);
    check_frame("hdrrow", 0);

    for (int r = 0; r < NROW; r++) fmap[r] = '1;
    send_frame(TRL);
    collect(0, 3000, -1);
    chk("ones cnt", hit_count, 1521);
    check_frame("ones", 0);

    clear_map();
    fmap[1][1] = 1'b1; fmap[30][30] = 1'b1;
    send_frame(TRL);
    collect(0, 2000, 5);
    chk("drop pulses", n_drop, 1);
    check_frame("drop", 0);
    chk("drop busy", busy, 0);

    clear_map();
    send_frame(TRL);
    collect(0, 2000, -1);
    check_frame("empty", 0);

    clear_map();
    fmap[2][2] = 1'b1; fmap[2][3] = 1'b1;
    send_frame(TRL);
    w = 0;
    while (!hif.hit_valid && w < 300) begin
      tick();
      w++;
    end
    chk("rst wait valid", hif.hit_valid, 1);
    hif.hit_ready = 1'b1;
    tick();
    hif.hit_ready = 1'b0;
    tick();
    chk("pre-rst y", hif.hit_y, 3);
    chk("pre-rst cnt", hit_count, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst outputs",
        {hif.hit_valid, hif.hit_x, hif.hit_y, hit_count,
         busy, frame_done, frame_err, frame_drop}, 0);
    tick();
    reset_n = 1'b1;
    busy_hi = 0;
    for (int c = 0; c < 12; c++) begin
      data_in = (c % 3 == 1) ? TRL : FILL;
      tick();
      if (busy) busy_hi++;
    end
    chk("post-rst busy", busy_hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
